// File: rtl/adder_bcd_scan_display.sv
// Adds two unsigned operands on a load strobe, converts the registered sum to BCD
// with a sequential double-dabble engine and scans it onto a multiplexed seven-segment display.
module adder_bcd_scan_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              load,
  output logic              busy,
  output logic              Cout,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        Display
);

  localparam int SW  = WIDTH + 1;            // sum width, carry included
  localparam int BW  = DIGITS * 4;           // BCD field width
  localparam int RW  = BW + SW;              // double-dabble shift register width
  localparam int CW  = $clog2(SW + 1);
  localparam int RCW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, next_state;
  logic            capture, shift_en, commit;
  logic [SW-1:0]   sum;
  logic [RW-1:0]   sreg, adj;
  logic [CW-1:0]   shift_cnt;
  logic [BW-1:0]   digits;
  logic [RCW-1:0]  refresh_cnt;
  logic [IW-1:0]   idx;
  logic [DIGITS-1:0] blank;
  logic [3:0]      sel_digit;
  logic            sel_blank;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (latch).
    next_state = state;
    case (state)
      IDLE:    if (load) next_state = SHIFT;
      SHIFT:   if (shift_cnt == CW'(WIDTH)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    capture  = (state == IDLE) && load;
    shift_en = (state == SHIFT);
    commit   = (state == DONE);
  end

  // ---------------- double-dabble datapath ----------------
  assign sum = SW'(A) + SW'(B);

  // Correct every BCD nibble >= 5 before it is doubled by the shift.
  always_comb begin
    adj = sreg;
    for (int d = 0; d < DIGITS; d++) begin
      if (sreg[SW + 4*d +: 4] >= 4'd5)
        adj[SW + 4*d +: 4] = sreg[SW + 4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      sreg      <= '0;
      shift_cnt <= '0;
      Cout      <= 1'b0;
      digits    <= '0;
    end else begin
      if (capture) begin
        sreg      <= {{BW{1'b0}}, sum};
        shift_cnt <= '0;
        Cout      <= sum[WIDTH];
      end else if (shift_en) begin
        sreg      <= adj << 1;
        shift_cnt <= shift_cnt + 1'b1;
      end
      if (commit)
        digits <= sreg[RW-1 -: BW];
    end
  end

  // ---------------- display scan ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == RCW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // A digit above 0 is blank while it and everything above it are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run && (digits[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
  end

  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_digit = digits[4*i +: 4];
        sel_blank = blank[i];
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Anode and segments share one register stage so they always switch on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode   <= ~DIGITS'(1);
      Display <= 7'b1000000;
    end else begin
      anode   <= ~(DIGITS'(1) << idx);
      Display <= sel_blank ? SEG_BLANK : seg7(sel_digit);
    end
  end

endmodule

// File: tb/tb_adder_bcd_scan_display.sv
// Self-checking bench for adder_bcd_scan_display: table-driven sums plus hand sequences
// for load-while-busy, reset mid-conversion and the digit scan order.
module tb_adder_bcd_scan_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000,
                         BL = 7'b1111111;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cout;
    logic [20:0] segs;   // {digit2, digit1, digit0}
    string       name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] A = '0, B = '0;
  logic       load = 1'b0;
  logic       busy, Cout;
  logic [2:0] anode;
  logic [6:0] Display;

  int passed = 0;
  int total  = 0;

  adder_bcd_scan_display #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .load(load),
    .busy(busy), .Cout(Cout), .anode(anode), .Display(Display)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Load a,b and count busy cycles; optionally re-pulse load (A=200) on busy cycle 3.
  task automatic do_load(input logic [7:0] a, input logic [7:0] b, input bit glitch,
                         output int busy_cycles);
    int guard;
    @(posedge clk); #1;
    A = a; B = b; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; A = ~a; B = ~b;
    busy_cycles = 0;
    guard = 0;
    while (busy && guard < 40) begin
      busy_cycles++;
      if (glitch && busy_cycles == 3) begin
        A = 8'd200; B = 8'd0; load = 1'b1;
      end
      @(posedge clk); #1;
      load = 1'b0;
      guard++;
    end
  endtask

  // Observe a full scan period and record the segments shown at each anode position.
  task automatic get_digits(output logic [20:0] segs, output bit bad_anode);
    segs = {BL, BL, BL};
    bad_anode = 1'b0;
    repeat (2) @(posedge clk);
    for (int s = 0; s < 16; s++) begin
      @(posedge clk); #1;
      case (anode)
        3'b110:  segs[6:0]   = Display;
        3'b101:  segs[13:7]  = Display;
        3'b011:  segs[20:14] = Display;
        default: bad_anode = 1'b1;
      endcase
    end
  endtask

  task automatic check_digits(input string tag, input logic [20:0] exp);
    logic [20:0] segs;
    bit bad;
    get_digits(segs, bad);
    check({tag, " anode one-hot-low"}, 32'(bad), 32'd0);
    check({tag, " digit0"}, 32'(segs[6:0]),   32'(exp[6:0]));
    check({tag, " digit1"}, 32'(segs[13:7]),  32'(exp[13:7]));
    check({tag, " digit2"}, 32'(segs[20:14]), 32'(exp[20:14]));
  endtask

  initial begin
    vec_t vecs[6];
    int   cyc;
    int   guard;
    logic [2:0] prev;
    logic [2:0] exp_an;

    vecs[0] = '{8'd5,   8'd7,   1'b0, {BL, S1, S2}, "5+7"};
    vecs[1] = '{8'd255, 8'd255, 1'b1, {S5, S1, S0}, "255+255"};
    vecs[2] = '{8'd0,   8'd0,   1'b0, {BL, BL, S0}, "0+0"};
    vecs[3] = '{8'd99,  8'd1,   1'b0, {S1, S0, S0}, "99+1"};
    vecs[4] = '{8'd128, 8'd128, 1'b1, {S2, S5, S6}, "128+128"};
    vecs[5] = '{8'd200, 8'd55,  1'b0, {S2, S5, S5}, "200+55"};

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    check("reset anode",   32'(anode),   32'b110);
    check("reset Display", 32'(Display), 32'(S0));
    check("reset busy",    32'(busy),    32'd0);
    check("reset Cout",    32'(Cout),    32'd0);
    #10 rst = 1'b0;
    check_digits("reset", {BL, BL, S0});

    foreach (vecs[i]) begin
      do_load(vecs[i].a, vecs[i].b, 1'b0, cyc);
      check({vecs[i].name, " busy cycles"}, 32'(cyc), 32'd10);
      check({vecs[i].name, " Cout"}, 32'(Cout), 32'(vecs[i].cout));
      check_digits(vecs[i].name, vecs[i].segs);
    end

    // Load re-issued while busy is ignored.
    do_load(8'd9, 8'd1, 1'b1, cyc);
    check("reload busy cycles", 32'(cyc), 32'd10);
    check("reload extra busy", 32'(busy), 32'd0);
    check_digits("9+1 reload", {BL, S1, S0});
    do_load(8'd200, 8'd0, 1'b0, cyc);
    check("200+0 busy cycles", 32'(cyc), 32'd10);
    check_digits("200+0", {S2, S0, S0});

    // Reset mid-conversion (busy cycle 5).
    @(posedge clk); #1;
    A = 8'd50; B = 8'd50; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midreset busy",    32'(busy),    32'd0);
    check("midreset anode",   32'(anode),   32'b110);
    check("midreset Display", 32'(Display), 32'(S0));
    check("midreset Cout",    32'(Cout),    32'd0);
    #2 rst = 1'b0;
    check_digits("after midreset", {BL, BL, S0});
    do_load(8'd3, 8'd4, 1'b0, cyc);
    check("3+4 busy cycles", 32'(cyc), 32'd10);
    check_digits("3+4", {BL, BL, S7});

    // Scan order and hold time: sync on the 011 -> 110 wrap, then 4 cycles per digit.
    prev  = anode;
    guard = 0;
    do begin
      prev = anode;
      @(posedge clk); #1;
      guard++;
    end while (!(prev == 3'b011 && anode == 3'b110) && guard < 40);
    check("scan sync", 32'(guard < 40), 32'd1);
    for (int s = 0; s < 12; s++) begin
      exp_an = (s < 4) ? 3'b110 : (s < 8) ? 3'b101 : 3'b011;
      check($sformatf("scan step %0d", s), 32'(anode), 32'(exp_an));
      @(posedge clk); #1;
    end
    check("scan wrap", 32'(anode), 32'b110);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
